// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// ---------------------------------------------------------------------------
// Purpose:
//    Generic pipeline stage register that sits between two stages of the
//    in-order core.
//    - Carries one packed payload bus with a valid/ready handshake.
//    - flush discards every held and incoming beat.
//    - Whenever no beat is held, the bubble encoding NOP_VAL is driven.
//    - With SKID=1 a second (skid) entry absorbs the beat that arrives in
//      the cycle back-pressure appears. in_ready can then be a register, so
//      out_ready never ripples combinationally back up the pipeline.
//    - With SKID=0 the stage is a single register with a combinational
//      in_ready.
//
// Parameters:
//    DATA_W   payload width in bits
//    NOP_VAL  payload driven on out_data while out_valid=0
//    SKID     1 = two entries with registered in_ready, 0 = single entry
//    CNT_W    width of the optional performance counters
//
// Ports:
//    clk         rising-edge clock
//    rst         synchronous active-high reset
//    flush       drop every held and incoming beat this cycle
//    in_valid    upstream beat valid
//    in_ready    stage can take a beat
//    in_data     upstream payload
//    out_valid   downstream beat valid
//    out_ready   downstream takes the beat
//    out_data    downstream payload (NOP_VAL while out_valid=0)
//    stall_cnt   cycles with out_valid=1 and out_ready=0  (PIPE_STAGE_PERF_EN)
//    bubble_cnt  cycles with out_valid=0 outside reset     (PIPE_STAGE_PERF_EN)
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//    Adds the saturating stall/bubble counters. The counters are cleared by
//    rst and are left alone by flush.
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int unsigned        DATA_W  = 111,
   parameter logic [DATA_W-1:0]  NOP_VAL = {DATA_W{1'b0}},
   parameter int unsigned        SKID    = 1,
   parameter int unsigned        CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   logic              mainValid_q, mainValid_d;
   logic [DATA_W-1:0] mainData_q,  mainData_d;
   logic              skidValid_q, skidValid_d;
   logic [DATA_W-1:0] skidData_q,  skidData_d;
   logic              inFire;
   logic              loadMain;

   // Reject nonsensical configurations at elaboration time.
   if (DATA_W == 0 || CNT_W == 0) begin : gBadParam
      $error("pipe_stage_skid: DATA_W and CNT_W must be non-zero");
   end

   // The main register may take a new value whenever its current beat is
   // either absent or leaving this cycle.
   assign inFire   = in_valid & in_ready;
   assign loadMain = ~mainValid_q | out_ready;

   // Next-state logic for both entries.
   // - The skid entry always drains into main before any fresh input, which
   //   keeps beats in order.
   // - A beat that arrives while main is stalled can only be accepted when
   //   the skid entry is free. In SKID=0 mode in_ready is already low in
   //   that case, so the skid path never fires.
   // - flush overrides everything else.
   // - Empty entries are parked at NOP_VAL so no stale payload lingers.
   always_comb begin
      mainValid_d = mainValid_q;
      mainData_d  = mainData_q;
      skidValid_d = skidValid_q;
      skidData_d  = skidData_q;

      if (loadMain) begin
         if (skidValid_q) begin
            mainValid_d = 1'b1;
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
            skidData_d  = NOP_VAL;
         end else if (inFire) begin
            mainValid_d = 1'b1;
            mainData_d  = in_data;
         end else begin
            mainValid_d = 1'b0;
            mainData_d  = NOP_VAL;
         end
      end else if (inFire) begin
         skidValid_d = 1'b1;
         skidData_d  = in_data;
      end

      if (flush) begin
         mainValid_d = 1'b0;
         mainData_d  = NOP_VAL;
         skidValid_d = 1'b0;
         skidData_d  = NOP_VAL;
      end
   end

   // Main output register.
   // - Reset empties it and parks the payload at the bubble encoding.
   // - While stalled, mainData_d equals mainData_q, so the payload is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         mainValid_q <= 1'b0;
         mainData_q  <= NOP_VAL;
      end else begin
         mainValid_q <= mainValid_d;
         mainData_q  <= mainData_d;
      end
   end

   if (SKID != 0) begin : gSkid
      logic inReady_q;

      // Skid entry plus registered ready.
      // - inReady_q tracks "skid entry free" for the coming cycle.
      // - It is computed from skidValid_d, so it rises again in the cycle
      //   right after the skid entry drains.
      // - Reset leaves the stage ready.
      always_ff @(posedge clk) begin
         if (rst) begin
            skidValid_q <= 1'b0;
            skidData_q  <= NOP_VAL;
            inReady_q   <= 1'b1;
         end else begin
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
            inReady_q   <= ~skidValid_d;
         end
      end

      // rst gates the registered ready so beats offered during reset are
      // never taken.
      assign in_ready = inReady_q & ~rst;
   end else begin : gNoSkid
      // Single-entry mode.
      // - There is no skid storage at all.
      // - in_ready follows the main register's ability to load.
      assign skidValid_q = 1'b0;
      assign skidData_q  = NOP_VAL;
      assign in_ready    = ~rst & loadMain;
   end

   // The explicit mux guarantees the bubble encoding on out_data whenever
   // no beat is offered.
   assign out_valid = mainValid_q;
   assign out_data  = mainValid_q ? mainData_q : NOP_VAL;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stallCnt_q;
   logic [CNT_W-1:0] bubbleCnt_q;

   // Saturating performance counters.
   // - stall counts cycles where a valid beat is blocked downstream.
   // - bubble counts cycles with nothing to offer.
   // - Only rst clears them; flush does not.
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCnt_q  <= '0;
         bubbleCnt_q <= '0;
      end else begin
         if (mainValid_q && !out_ready && stallCnt_q != '1) begin
            stallCnt_q <= stallCnt_q + 1'b1;
         end
         if (!mainValid_q && bubbleCnt_q != '1) begin
            bubbleCnt_q <= bubbleCnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt  = stallCnt_q;
   assign bubble_cnt = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// ---------------------------------------------------------------------------
// Drives one SKID=1 and one SKID=0 instance of pipe_stage_skid from the same
// inputs.
// Each instance is compared every cycle against its own reference model:
//    - A FIFO of held beats with capacity 2 (SKID=1) or capacity 1 (SKID=0).
//    - The model derives out_valid, out_data and in_ready from the FIFO
//      occupancy.
//    - With PIPE_STAGE_PERF_EN the model also tracks saturating stall and
//      bubble counts.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int DW   = 111;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef logic [DW-1:0] data_t;

   localparam data_t NOP = '0;

   logic  clk = 1'b0;
   logic  rst;
   logic  flush;
   logic  inValid;
   logic  outReady;
   data_t inData;

   logic  inReady1;
   logic  outValid1;
   data_t outData1;
   logic  inReady0;
   logic  outValid0;
   data_t outData0;
`ifdef PIPE_STAGE_PERF_EN
   logic [CW-1:0] stall1;
   logic [CW-1:0] bubble1;
   logic [CW-1:0] stall0;
   logic [CW-1:0] bubble0;
`endif

   data_t q1[$];
   data_t q0[$];
   int    stallM1;
   int    bubbleM1;
   int    stallM0;
   int    bubbleM0;
   bit    modelKnown;
   bit    lastAcc1;
   int    passCount;
   int    checkCount;

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1), .CNT_W(CW)) dutSkid (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(inReady1), .in_data(inData),
      .out_valid(outValid1), .out_ready(outReady), .out_data(outData1)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall1), .bubble_cnt(bubble1)
`endif
   );

   pipe_stage_skid #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(0), .CNT_W(CW)) dutNoSkid (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(inReady0), .in_data(inData),
      .out_valid(outValid0), .out_ready(outReady), .out_data(outData0)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall0), .bubble_cnt(bubble0)
`endif
   );

   // One comparison: count it, and report it if it does not hold.
   task automatic check(input string tag, input data_t obs, input data_t exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Compare both DUTs against the models.
   // - in_ready is always comparable, because rst forces it low.
   // - Every other output is checked only once the first reset has been
   //   applied.
   task automatic checkOutput();
      logic expRdy1;
      logic expRdy0;
      expRdy1 = !rst && (q1.size() < 2);
      expRdy0 = !rst && (q0.size() == 0 || outReady);
      check("skid.in_ready", data_t'(inReady1), data_t'(expRdy1));
      check("noskid.in_ready", data_t'(inReady0), data_t'(expRdy0));
      if (modelKnown) begin
         check("skid.out_valid", data_t'(outValid1), data_t'(q1.size() != 0));
         check("skid.out_data", outData1, (q1.size() != 0) ? q1[0] : NOP);
         check("noskid.out_valid", data_t'(outValid0), data_t'(q0.size() != 0));
         check("noskid.out_data", outData0, (q0.size() != 0) ? q0[0] : NOP);
`ifdef PIPE_STAGE_PERF_EN
         check("skid.stall_cnt", data_t'(stall1), data_t'(stallM1));
         check("skid.bubble_cnt", data_t'(bubble1), data_t'(bubbleM1));
         check("noskid.stall_cnt", data_t'(stall0), data_t'(stallM0));
         check("noskid.bubble_cnt", data_t'(bubble0), data_t'(bubbleM0));
`endif
      end
   endtask

   // Run one clock cycle.
   // - Drive the inputs, then check the outputs mid-cycle.
   // - Work out which beats move from the models' view of the current cycle.
   // - Advance the models at the rising edge.
   task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                input data_t d, input logic ordy);
      bit acc1;
      bit acc0;
      bit pop1;
      bit pop0;
      rst      = r;
      flush    = f;
      inValid  = iv;
      inData   = d;
      outReady = ordy;
      @(negedge clk);
      checkOutput();
      acc1     = iv && !r && (q1.size() < 2);
      acc0     = iv && !r && (q0.size() == 0 || ordy);
      pop1     = (q1.size() != 0) && ordy;
      pop0     = (q0.size() != 0) && ordy;
      lastAcc1 = acc1;
      @(posedge clk);
      if (r) begin
         stallM1  = 0;
         bubbleM1 = 0;
         stallM0  = 0;
         bubbleM0 = 0;
      end else begin
         if (q1.size() != 0 && !ordy && stallM1 < CMAX) stallM1++;
         if (q1.size() == 0 && bubbleM1 < CMAX) bubbleM1++;
         if (q0.size() != 0 && !ordy && stallM0 < CMAX) stallM0++;
         if (q0.size() == 0 && bubbleM0 < CMAX) bubbleM0++;
      end
      if (r || f) begin
         q1.delete();
         q0.delete();
      end else begin
         if (pop1) void'(q1.pop_front());
         if (acc1) q1.push_back(d);
         if (pop0) void'(q0.pop_front());
         if (acc0) q0.push_back(d);
      end
      if (r) modelKnown = 1'b1;
      #1;
   endtask

   // Directed scenarios first, then a randomized soak, then the summary.
   initial begin
      data_t bp[3];
      int    idx;
      bit    rr;
      bit    ff;
      bit    vv;
      bit    oo;
      data_t dd;

      passCount  = 0;
      checkCount = 0;
      modelKnown = 1'b0;
      stallM1    = 0;
      bubbleM1   = 0;
      stallM0    = 0;
      bubbleM0   = 0;
      rst        = 1'b1;
      flush      = 1'b0;
      inValid    = 1'b0;
      inData     = NOP;
      outReady   = 1'b0;
      @(posedge clk);
      #1;

      // Reset with a beat offered: it must never be captured.
      applyStimulus(1, 0, 1, data_t'('hAB), 1);
      applyStimulus(1, 0, 1, data_t'('hAB), 1);
      applyStimulus(0, 0, 0, NOP, 1);
      applyStimulus(0, 0, 0, NOP, 1);

      // Back-to-back streaming of beats 1..8.
      for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 1, data_t'(i), 1);
      applyStimulus(0, 0, 0, NOP, 1);
      applyStimulus(0, 0, 0, NOP, 1);

      // Back-pressure: out_ready low for three cycles starting in cycle 1.
      bp[0] = data_t'('h10);
      bp[1] = data_t'('h11);
      bp[2] = data_t'('h12);
      idx   = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(0, 0, idx < 3, (idx < 3) ? bp[idx] : NOP, !(c >= 1 && c < 4));
         if (lastAcc1 && idx < 3) idx++;
      end

      // Flush while the skid stage is full, with a third beat offered.
      applyStimulus(0, 0, 1, data_t'('h20), 0);
      applyStimulus(0, 0, 1, data_t'('h21), 0);
      applyStimulus(0, 1, 1, data_t'('h22), 0);
      applyStimulus(0, 0, 0, NOP, 1);
      applyStimulus(0, 0, 0, NOP, 1);

      // Long stall that saturates the stall counter.
      // flush must keep the counter; rst must clear it.
      applyStimulus(0, 0, 1, data_t'('h30), 0);
      for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, NOP, 0);
      applyStimulus(0, 1, 0, NOP, 0);
      applyStimulus(0, 0, 0, NOP, 1);
      applyStimulus(1, 0, 0, NOP, 1);
      applyStimulus(0, 0, 0, NOP, 1);

      // Randomized soak with occasional flush and reset.
      for (int c = 0; c < 600; c++) begin
         rr = ($urandom_range(0, 63) == 0);
         ff = ($urandom_range(0, 15) == 0);
         vv = ($urandom_range(0, 3) != 0);
         oo = ($urandom_range(0, 3) != 0);
         dd = data_t'({$urandom(), $urandom(), $urandom(), $urandom()});
         applyStimulus(rr, ff, vv, dd, oo);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
